// File: rtl/rgmii_rx_if.sv
// rgmii_rx_if: received frame byte stream with per-frame end-of-frame status
interface rgmii_rx_if;
  logic [7:0] rx_data;
  logic rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_len_err;
  modport master(output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_len_err);
  modport slave(input rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_len_err);
endinterface

// File: rtl/rgmii_rx.sv
// rgmii_rx: RGMII receive framer, de-DDR, preamble/SFD strip, FCS-stripped stream, CRC-32 and length check
module rgmii_rx #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk125,
  input  logic        rst_n,
  input  logic        rxctl,
  input  logic [3:0]  rxd,
  rgmii_rx_if.master  rx,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  state_t st;
  logic [3:0] lo, hi;
  logic ctl, cv, armed, ovf, first;
  logic [7:0] b;
  logic [15:0] len;
  logic [31:0] crc, crc_n;
  logic [3:0][7:0] dl;
  assign b = {hi, lo};
  always_comb begin
    crc_n = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) crc_n = crc_n[0] ? (crc_n >> 1) ^ 32'hEDB88320 : crc_n >> 1;
  end
  always_ff @(posedge clk125 or negedge rst_n)
    if (!rst_n) begin
      lo <= '0;
      ctl <= 1'b0;
      cv <= 1'b0;
    end else begin
      lo <= rxd;
      ctl <= rxctl;
      cv <= 1'b1;
    end
  always_ff @(negedge clk125 or negedge rst_n)
    if (!rst_n) hi <= '0;
    else hi <= rxd;
  // cv masks the reset value of ctl; armed blocks syncing until an idle cycle has been seen
  always_ff @(posedge clk125 or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      armed <= 1'b0;
      ovf <= 1'b0;
      first <= 1'b0;
      len <= '0;
      crc <= '1;
      dl <= '0;
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_sof <= 1'b0;
      rx.rx_eof <= 1'b0;
      rx.rx_crc_ok <= 1'b0;
      rx.rx_len_err <= 1'b0;
      good_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      rx.rx_valid <= 1'b0;
      rx.rx_sof <= 1'b0;
      rx.rx_eof <= 1'b0;
      rx.rx_crc_ok <= 1'b0;
      rx.rx_len_err <= 1'b0;
      good_cnt <= good_cnt + {15'd0, rx.rx_eof & rx.rx_crc_ok & ~rx.rx_len_err & ~&good_cnt};
      bad_cnt <= bad_cnt + {15'd0, rx.rx_eof & ~(rx.rx_crc_ok & ~rx.rx_len_err) & ~&bad_cnt};
      if (cv) begin
        armed <= armed | ~ctl;
        case (st)
          IDLE: if (ctl) begin
            st <= !armed ? DROP : b == 8'h55 ? PRE : b == 8'hD5 ? DATA : DROP;
            len <= '0;
            crc <= '1;
            first <= 1'b1;
          end
          PRE: if (!ctl) st <= IDLE;
          else if (b == 8'hD5) begin
            st <= DATA;
            len <= '0;
            crc <= '1;
            first <= 1'b1;
          end else if (b != 8'h55) st <= DROP;
          DATA: if (!ctl) begin
            st <= IDLE;
            rx.rx_eof <= 1'b1;
            rx.rx_crc_ok <= crc == 32'hDEBB20E3;
            rx.rx_len_err <= len < 16'(MIN_LEN);
          end else if (len == 16'(MAX_LEN)) begin
            st <= DROP;
            ovf <= 1'b1;
          end else begin
            dl <= {dl[2:0], b};
            len <= len + 16'd1;
            crc <= crc_n;
            if (len >= 16'd4) begin
              rx.rx_valid <= 1'b1;
              rx.rx_data <= dl[3];
              rx.rx_sof <= first;
              first <= 1'b0;
            end
          end
          DROP: if (!ctl) begin
            st <= IDLE;
            ovf <= 1'b0;
            rx.rx_eof <= ovf;
            rx.rx_len_err <= ovf;
          end
        endcase
      end
    end
endmodule
